fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue sitting directly downstream of `i_cache`. It generates the fetch PC and read/abort controls for the cache and captures each 128-bit line (four 32-bit instructions) into a circular FIFO. It presents one instruction plus its PC per cycle to decode. A branch/jump redirect flushes the queue, aborts the in-flight cache read and restarts fetch at the target.

## Interface
- `DEPTH`, 16: queue entries of 32 bits; power of two, ≥ 8.
- `RESET_PC`, 32'h0: fetch address after reset; word-aligned.

- `i_clk`  input  1  clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `pc_in`  output  32  fetch address to `i_cache`; bits [1:0] always 0.
- `rd_en`  output  1  cache read request.
- `abort`  output  1  cancels the in-flight cache read.
- `Dout`  input  128  cache line; word k at [32k+31:32k] is address {pc_in[31:4], k, 2'b00}.
- `Dout_valid`  input  1  `Dout` valid for the current `pc_in`.
- `jmp_branch_address`  input  32  redirect target; bits [1:0] ignored.
- `jmp_branch_valid`  input  1  redirect strobe, one cycle.
- `dq_rd_en`  input  1  decode pops the head entry.
- `instr`  output  32  head instruction; defined only when `empty`=0.
- `instr_pc`  output  32  PC of the head instruction.
- `empty`  output  1  queue holds no entries.

## Operation
- FSM states:
  - RUN: reset state.
  - FLUSH: one-cycle abort.
- RUN → FLUSH on `jmp_branch_valid`. FLUSH → RUN unconditionally, unless `jmp_branch_valid` is high again, which keeps FLUSH with the new target.
- `rd_en` = (state==RUN) && (count ≤ DEPTH−4), using the registered count. Pops only add space, so overflow is impossible.
- `abort` = (state==FLUSH).
- Line accept occurs at an edge where `rd_en` && `Dout_valid` && !`jmp_branch_valid`:
  - Let s = pc_in[3:2] and n = 4−s.
  - Words s..3 are written in order at wr_ptr, and wr_ptr advances by n (mod DEPTH).
  - pc_in ← {pc_in[31:4]+1, 4'b0}.
- `Dout_valid` while `rd_en`=0 is ignored.
- `pc_in` and `rd_en` hold stable while waiting for `Dout_valid`, for any number of cycles.
- Pop occurs at an edge where `dq_rd_en` && !`empty` && !`jmp_branch_valid`:
  - rd_ptr advances by 1.
  - `instr_pc` (head_pc register) increases by 4.
  - Pop while empty is ignored.
- Count update: count ← count + n·accept − pop. A push and a pop may occur in the same cycle.
- Count width is log2(DEPTH)+1; pointers are log2(DEPTH) and wrap modulo DEPTH.
- Redirect at an edge:
  - count, rd_ptr and wr_ptr ← 0.
  - pc_in ← {jmp_branch_address[31:2], 2'b00}.
  - head_pc ← the same value.
  - A line or pop in the same cycle is discarded.
- head_pc tracks the sequential stream: queue contents are always contiguous between redirects.
- `instr` = mem[rd_ptr]; `empty` = (count==0).

## Timing
- Reset values, applied immediately on `rst` assertion regardless of clock:
  - `pc_in`=RESET_PC, `instr_pc`=RESET_PC
  - `abort`=0, `empty`=1
  - state=RUN, so `rd_en`=1 in the first cycle after reset release
  - count and pointers 0, `instr` = 0
- Line accepted at edge N: `empty`=0 and `instr`/`instr_pc` show the first written word from cycle N+1.
- Redirect at edge N:
  - cycle N+1: `abort`=1, `rd_en`=0, `pc_in`=target, `empty`=1.
  - cycle N+2: `abort`=0 and `rd_en`=1.
- `rd_en` deasserts the cycle after count exceeds DEPTH−4. It reasserts the cycle after count ≤ DEPTH−4.
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.

## Structure
- `fetch_pkg`:
  - constants `INSTR_W`=32, `LINE_W`=128, `WORDS_PER_LINE`=4
  - FSM enum `fq_state_t` {RUN, FLUSH}
  - helper function for valid-word count from pc[3:2]
- Sub-module `fetch_queue_mem`: DEPTH×32 register array with a 4-word masked write port at base pointer plus lane offsets (mod DEPTH), and one asynchronous read port. No reset on the array itself.
- Top level holds the FSM, pc_in, head_pc, pointers and count.

## Test plan
- Reset, then cache returns words A0..A3 on the first cycle → `instr`=A0 with `instr_pc`=0. Three more pops give A1, A2, A3 at PC 4, 8, C, then `empty`=1. `pc_in`=0x10.
- No pops, `Dout_valid` always 1, DEPTH=16 → after 4 lines count=16, `rd_en`=0 and `pc_in`=0x40 held. `rd_en` returns only after the 4th pop (count=12).
- Redirect to 0x108 → one-cycle `abort`, `pc_in`=0x108, queue empty. The next line writes only words 2 and 3, with `instr_pc` 0x108 and 0x10C, and `pc_in` becomes 0x110.
- Redirect in the same cycle as `Dout_valid` and `dq_rd_en` with count=5 → line dropped, count=0, `empty`=1.
- `Dout_valid` held low 5 cycles → `pc_in` and `rd_en` unchanged throughout; the line is accepted in cycle 6.
- `rst` pulsed mid-fill between clock edges, with count=9 and `pc_in`=0x30 → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, FSM encoding and line-alignment helper for the fetch queue.
package fetch_pkg;
  localparam int INSTR_W        = 32;
  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fq_state_t;

  // Number of usable words in a line when fetch enters at word slot s.
  function automatic logic [2:0] valid_words(input logic [1:0] s);
    return 3'(3'd4 - {1'b0, s});
  endfunction
endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x 32 instruction store: 4-lane masked write at wr_ptr+lane, async read.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                                     clk,
  input  logic [WORDS_PER_LINE-1:0]                we,
  input  logic [AW-1:0]                            wr_ptr,
  input  logic [WORDS_PER_LINE-1:0][INSTR_W-1:0]   wr_data,
  input  logic [AW-1:0]                            rd_ptr,
  output logic [INSTR_W-1:0]                       rd_data
);
  logic [INSTR_W-1:0]                    mem [DEPTH];
  logic [WORDS_PER_LINE-1:0][AW-1:0]     lane_addr;

  // Lane addresses wrap naturally because DEPTH is a power of two.
  for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_lane
    assign lane_addr[g] = wr_ptr + AW'(g);
  end

  // Masked multi-lane write; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < WORDS_PER_LINE; j++)
      if (we[j]) mem[lane_addr[j]] <= wr_data[j];
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: drives i_cache PC/read/abort, buffers lines, feeds decode one word per cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               i_clk,
  input  logic               rst,
  output logic [31:0]        pc_in,
  output logic               rd_en,
  output logic               abort,
  input  logic [LINE_W-1:0]  Dout,
  input  logic               Dout_valid,
  input  logic [31:0]        jmp_branch_address,
  input  logic               jmp_branch_valid,
  input  logic               dq_rd_en,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_state_t                              state, state_nxt;
  logic [AW-1:0]                          rd_ptr, wr_ptr;
  logic [CW-1:0]                          count;
  logic [31:0]                            head_pc;
  logic                                   accept, pop;
  logic [1:0]                             s;
  logic [2:0]                             n;
  logic [WORDS_PER_LINE-1:0]              we;
  logic [WORDS_PER_LINE-1:0][INSTR_W-1:0] wdata;
  logic [INSTR_W-1:0]                     rd_data;
  logic                                   unused_addr_lsb;

  assign unused_addr_lsb = ^jmp_branch_address[1:0];

  assign s      = pc_in[3:2];
  assign n      = valid_words(s);
  assign rd_en  = (state == RUN) && (count <= CW'(DEPTH - 4));
  assign abort  = (state == FLUSH);
  assign empty  = (count == '0);
  assign accept = rd_en && Dout_valid && !jmp_branch_valid;
  assign pop    = dq_rd_en && !empty && !jmp_branch_valid;

  // Shift the line so word s lands in lane 0; lanes 0..n-1 are written.
  assign wdata = Dout >> {s, 5'b0};
  assign we    = accept ? (4'b1111 >> s) : '0;

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (i_clk),
    .we      (we),
    .wr_ptr  (wr_ptr),
    .wr_data (wdata),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state: a redirect always (re)enters the one-cycle abort.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (jmp_branch_valid) state_nxt = FLUSH;
      FLUSH:   state_nxt = jmp_branch_valid ? FLUSH : RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Fetch PC, head PC, pointers and occupancy; redirect overrides push/pop.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      pc_in   <= RESET_PC;
      head_pc <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else if (jmp_branch_valid) begin
      pc_in   <= {jmp_branch_address[31:2], 2'b00};
      head_pc <= {jmp_branch_address[31:2], 2'b00};
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(n);
        pc_in  <= {pc_in[31:4] + 28'd1, 4'b0};
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        head_pc <= head_pc + 32'd4;
      end
      count <= count + (accept ? CW'(n) : CW'(0)) - CW'(pop);
    end
  end

  // Gate with empty so the unreset array never leaks X/stale data out.
  assign instr    = empty ? '0 : rd_data;
  assign instr_pc = head_pc;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench: row table + hand sequences, scoreboard of expected words.
module tb_fetch_queue;
  logic         i_clk = 1'b0;
  logic         rst   = 1'b1;
  logic [31:0]  pc_in;
  logic         rd_en, abort;
  logic [127:0] Dout;
  logic         Dout_valid = 1'b0;
  logic [31:0]  jba = '0;
  logic         jbv = 1'b0;
  logic         dq_rd_en = 1'b0;
  logic [31:0]  instr, instr_pc;
  logic         empty;

  always #5 i_clk = ~i_clk;

  fetch_queue #(.DEPTH(16), .RESET_PC(32'h0)) dut (
    .i_clk              (i_clk),
    .rst                (rst),
    .pc_in              (pc_in),
    .rd_en              (rd_en),
    .abort              (abort),
    .Dout               (Dout),
    .Dout_valid         (Dout_valid),
    .jmp_branch_address (jba),
    .jmp_branch_valid   (jbv),
    .dq_rd_en           (dq_rd_en),
    .instr              (instr),
    .instr_pc           (instr_pc),
    .empty              (empty)
  );

  // Unique content per word address so misordering shows up.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Cache model: always presents the line for the current fetch PC.
  always_comb begin
    Dout = '0;
    for (int k = 0; k < 4; k++)
      Dout[32*k +: 32] = word_at({pc_in[31:4], 2'(k), 2'b00});
  end

  typedef struct {
    logic        dv, jbv;
    logic [31:0] tgt;
    logic        pop;
    logic [31:0] pc;
    logic        rden, abort, empty;
    logic [31:0] ipc;
  } rec_t;

  typedef struct {
    logic [31:0] pc, data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  logic [31:0] prev_pc;
  logic        prev_rden, prev_empty;
  rec_t        tbl[13];

  function automatic rec_t mk(input logic dv, jbv, input logic [31:0] tgt, input logic pop,
                              input logic [31:0] pc, input logic rden, ab, em,
                              input logic [31:0] ipc);
    rec_t r;
    r.dv = dv; r.jbv = jbv; r.tgt = tgt; r.pop = pop;
    r.pc = pc; r.rden = rden; r.abort = ab; r.empty = em; r.ipc = ipc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive, score head before the edge, predict pushes, check after edge.
  task automatic step(input rec_t r);
    exp_t e;
    logic [31:0] a;
    Dout_valid = r.dv; jbv = r.jbv; jba = r.tgt; dq_rd_en = r.pop;
    if (r.pop && !prev_empty && !r.jbv) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got entry want none at %0t", $time);
      end else begin
        chk("instr", instr, sb[0].data);
        chk("head_pc", instr_pc, sb[0].pc);
        void'(sb.pop_front());
      end
    end
    if (r.jbv) sb.delete();
    else if (r.dv && prev_rden)
      for (int k = int'(prev_pc[3:2]); k < 4; k++) begin
        a = {prev_pc[31:4], 2'(k), 2'b00};
        e.pc = a; e.data = word_at(a);
        sb.push_back(e);
      end
    @(posedge i_clk); #1;
    chk("pc_in", pc_in, r.pc);
    chk("rd_en", 32'(rd_en), 32'(r.rden));
    chk("abort", 32'(abort), 32'(r.abort));
    chk("empty", 32'(empty), 32'(r.empty));
    chk("instr_pc", instr_pc, r.ipc);
    prev_pc = r.pc; prev_rden = r.rden; prev_empty = r.empty;
    Dout_valid = 1'b0; jbv = 1'b0; dq_rd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc_in"}, pc_in, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_abort"}, 32'(abort), 32'h0);
    chk({tag, "_empty"}, 32'(empty), 32'h1);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'h1);
    chk({tag, "_instr"}, instr, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; Dout_valid = 1'b0; jbv = 1'b0; jba = '0; dq_rd_en = 1'b0;
    @(posedge i_clk); #1;
    chk_reset_vals("rst");
    @(negedge i_clk);
    rst = 1'b0;
    prev_pc = 32'h0; prev_rden = 1'b1; prev_empty = 1'b1;
    sb.delete();
  endtask

  initial begin
    // Basic line, drains, redirect to a mid-line target, redirect while flushing.
    tbl[0]  = mk(1, 0, 0,        0, 32'h10,  1, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0,        1, 32'h10,  1, 0, 0, 32'h4);
    tbl[2]  = mk(0, 0, 0,        1, 32'h10,  1, 0, 0, 32'h8);
    tbl[3]  = mk(0, 0, 0,        1, 32'h10,  1, 0, 0, 32'hC);
    tbl[4]  = mk(0, 0, 0,        1, 32'h10,  1, 0, 1, 32'h10);
    tbl[5]  = mk(1, 1, 32'h10B,  1, 32'h108, 0, 1, 1, 32'h108);
    tbl[6]  = mk(1, 0, 0,        0, 32'h108, 1, 0, 1, 32'h108);
    tbl[7]  = mk(1, 0, 0,        0, 32'h110, 1, 0, 0, 32'h108);
    tbl[8]  = mk(0, 0, 0,        1, 32'h110, 1, 0, 0, 32'h10C);
    tbl[9]  = mk(1, 0, 0,        1, 32'h120, 1, 0, 0, 32'h110);
    tbl[10] = mk(0, 1, 32'h40,   0, 32'h40,  0, 1, 1, 32'h40);
    tbl[11] = mk(0, 1, 32'h84,   0, 32'h84,  0, 1, 1, 32'h84);
    tbl[12] = mk(0, 0, 0,        0, 32'h84,  1, 0, 1, 32'h84);

    do_reset();
    for (int i = 0; i < 13; i++) step(tbl[i]);

    // Fill to 16 with no pops: rd_en drops, then returns only at count 12.
    do_reset();
    for (int i = 1; i <= 3; i++) step(mk(1, 0, 0, 0, 32'(i * 16), 1, 0, 0, 32'h0));
    step(mk(1, 0, 0, 0, 32'h40, 0, 0, 0, 32'h0));
    step(mk(1, 0, 0, 0, 32'h40, 0, 0, 0, 32'h0));
    for (int i = 1; i <= 3; i++) step(mk(1, 0, 0, 1, 32'h40, 0, 0, 0, 32'(i * 4)));
    step(mk(1, 0, 0, 1, 32'h40, 1, 0, 0, 32'h10));
    step(mk(1, 0, 0, 0, 32'h50, 0, 0, 0, 32'h10));
    step(mk(0, 0, 0, 1, 32'h50, 0, 0, 0, 32'h14));

    // Redirect colliding with line and pop at count 5.
    do_reset();
    step(mk(1, 0, 0, 0, 32'h10, 1, 0, 0, 32'h0));
    step(mk(1, 0, 0, 1, 32'h20, 1, 0, 0, 32'h4));
    step(mk(0, 0, 0, 1, 32'h20, 1, 0, 0, 32'h8));
    step(mk(0, 0, 0, 1, 32'h20, 1, 0, 0, 32'hC));
    step(mk(1, 1, 32'h200, 1, 32'h200, 0, 1, 1, 32'h200));
    step(mk(0, 0, 0, 0, 32'h200, 1, 0, 1, 32'h200));
    step(mk(1, 0, 0, 1, 32'h210, 1, 0, 0, 32'h200));
    step(mk(0, 0, 0, 1, 32'h210, 1, 0, 0, 32'h204));

    // Cache stalls for 5 cycles; request must hold steady.
    do_reset();
    for (int i = 0; i < 5; i++) step(mk(0, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0));
    step(mk(1, 0, 0, 0, 32'h10, 1, 0, 0, 32'h0));
    step(mk(0, 0, 0, 1, 32'h10, 1, 0, 0, 32'h4));

    // Async reset mid-cycle with count 9, pc_in 0x30.
    do_reset();
    for (int i = 1; i <= 3; i++) step(mk(1, 0, 0, 0, 32'(i * 16), 1, 0, 0, 32'h0));
    for (int i = 1; i <= 3; i++) step(mk(0, 0, 0, 1, 32'h30, 1, 0, 0, 32'(i * 4)));
    #2 rst = 1'b1;
    #1 chk_reset_vals("async");
    @(negedge i_clk);
    rst = 1'b0;
    prev_pc = 32'h0; prev_rden = 1'b1; prev_empty = 1'b1;
    sb.delete();
    step(mk(1, 0, 0, 0, 32'h10, 1, 0, 0, 32'h0));
    step(mk(0, 0, 0, 1, 32'h10, 1, 0, 0, 32'h4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
